// File: rtl/cflog_pkg.sv
// -----------------------------------------------------------------------------
// cflog_pkg
// Shared definitions for the control-flow log writer:
//   state_e          - writer FSM encoding (IDLE / ISSUE / FLUSH)
//   entry_t          - one buffered log record {addr, data}
//   LOG_BASE_DEFAULT - default byte base of the CFLog region
//   log_addr()       - base + offset, 16-bit wrap, forced even
// -----------------------------------------------------------------------------
package cflog_pkg;

  localparam logic [15:0] LOG_BASE_DEFAULT = 16'hE000;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    FLUSH = 2'b10
  } state_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } entry_t;

  // Carry out of bit 15 is discarded; bit 0 is cleared so a stray odd
  // offset can never produce a misaligned halfword write.
  function automatic logic [15:0] log_addr(input logic [15:0] base,
                                           input logic [15:0] ptr);
    logic [15:0] sum;
    sum = base + ptr;
    return {sum[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/cflog_writer_if.sv
// -----------------------------------------------------------------------------
// cflog_writer_if
// Memory write port of the CFLog writer.
//   mem_req   - write request (writer -> memory)
//   mem_addr  - byte write address (writer -> memory)
//   mem_wdata - write data (writer -> memory)
//   mem_gnt   - write accepted when high together with mem_req (memory -> writer)
// Modports: master = writer side, slave = memory side.
// -----------------------------------------------------------------------------
interface cflog_writer_if;

  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_gnt;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_wdata,
    input  mem_gnt
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_wdata,
    output mem_gnt
  );

endinterface

// File: rtl/cflog_fifo.sv
// -----------------------------------------------------------------------------
// cflog_fifo
// Small synchronous FIFO of log entries with a combinational head.
//   clk       - clock, rising edge
//   reset_n   - asynchronous active-low reset (pointers and count only)
//   push      - write push_data this cycle (ignored when full without pop)
//   push_data - entry to store
//   pop       - retire the head this cycle (ignored when empty)
//   head      - oldest stored entry
//   full      - count == DEPTH
//   empty     - count == 0
//   count     - number of stored entries
// A push and a pop in the same cycle are both honoured even when full,
// because the pop frees the slot the push lands in.
// -----------------------------------------------------------------------------
module cflog_fifo
  import cflog_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  output entry_t                     head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          slots [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == CW'(0));
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = slots[rd_ptr];

  // Control state: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; stale contents are never visible because the
  // head is only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cflog_writer.sv
// -----------------------------------------------------------------------------
// cflog_writer
// Buffers control-flow log entries from the log monitor and writes them to
// data memory one halfword record at a time.
//   clk           - clock, rising edge
//   reset_n       - asynchronous active-low reset
//   hw_wr_en      - log-write request, one entry per cycle high
//   cflow_log_ptr - byte offset of the entry inside the log region
//   pc_nxt        - branch destination to record
//   flush         - flush request (level; its rising edge starts a flush)
//   mem           - memory write port (cflog_writer_if.master)
//   busy          - entries buffered or a write outstanding
//   ovf           - sticky: an entry was dropped because the FIFO was full
//   flush_done    - one-cycle pulse once everything queued before the
//                   flush request (and during it) has been written
// Entries go straight into the FIFO on the capture edge; the FSM sees the
// non-empty FIFO on the following edge, giving a two-cycle request latency.
// -----------------------------------------------------------------------------
module cflog_writer
  import cflog_pkg::*;
#(
  parameter logic [15:0] LOG_BASE   = LOG_BASE_DEFAULT,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  hw_wr_en,
  input  logic [15:0]           cflow_log_ptr,
  input  logic [15:0]           pc_nxt,
  input  logic                  flush,
  cflog_writer_if.master        mem,
  output logic                  busy,
  output logic                  ovf,
  output logic                  flush_done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e          state_q;
  state_e          state_d;
  logic            flush_q;
  logic            flush_pend_q;
  logic            flush_pend_d;
  logic            ovf_q;

  logic            flush_rise;
  logic            issue;
  logic            pop;
  logic            drop;
  logic            last_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  entry_t          new_entry;
  entry_t          head;

  assign new_entry  = '{addr: log_addr(LOG_BASE, cflow_log_ptr), data: pc_nxt};

  assign issue      = (state_q == ISSUE);
  assign pop        = issue & mem.mem_gnt;
  // A full FIFO still accepts the entry when the head retires this cycle.
  assign drop       = hw_wr_en & fifo_full & ~pop;
  // The FIFO drains this cycle only if no new entry arrives alongside the pop.
  assign last_pop   = pop & (fifo_count == CW'(1)) & ~hw_wr_en;
  assign flush_rise = flush & ~flush_q;

  cflog_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (hw_wr_en),
    .push_data (new_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next-state and flush bookkeeping.
  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty)
          state_d = ISSUE;
        else if (flush_rise || flush_pend_q)
          state_d = FLUSH;
      end
      ISSUE: begin
        if (last_pop)
          state_d = (flush_pend_q || flush_rise) ? FLUSH : IDLE;
      end
      FLUSH: begin
        state_d = fifo_empty ? IDLE : ISSUE;
      end
      default: state_d = IDLE;
    endcase

    // A new request arriving during FLUSH survives, so it earns its own pulse.
    if (state_q == FLUSH) flush_pend_d = 1'b0;
    if (flush_rise)       flush_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      flush_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_q      <= flush;
      flush_pend_q <= flush_pend_d;
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Outputs decode from registered state, so reset clears them immediately.
  assign mem.mem_req   = issue;
  assign mem.mem_addr  = issue ? head.addr : 16'h0000;
  assign mem.mem_wdata = issue ? head.data : 16'h0000;
  assign busy          = (fifo_count != CW'(0)) | issue;
  assign ovf           = ovf_q;
  assign flush_done    = (state_q == FLUSH);

endmodule

// File: tb/tb_cflog_writer.sv
// -----------------------------------------------------------------------------
// tb_cflog_writer
// Scoreboarded bench for cflog_writer: expected records are queued as
// entries are driven and compared against each granted memory write.
// -----------------------------------------------------------------------------
module tb_cflog_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        hw_wr_en = 1'b0;
  logic [15:0] cflow_log_ptr = 16'h0000;
  logic [15:0] pc_nxt = 16'h0000;
  logic        flush = 1'b0;
  logic        busy;
  logic        ovf;
  logic        flush_done;

  cflog_writer_if mem_bus();

  cflog_writer #(
    .LOG_BASE   (16'hE000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .hw_wr_en      (hw_wr_en),
    .cflow_log_ptr (cflow_log_ptr),
    .pc_nxt        (pc_nxt),
    .flush         (flush),
    .mem           (mem_bus),
    .busy          (busy),
    .ovf           (ovf),
    .flush_done    (flush_done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          grant_cnt = 0;
  int          last_grant_cyc = 0;
  int          fd_cnt = 0;
  int          fd_cyc = 0;
  logic [31:0] exp_q [$];

  function automatic logic [15:0] exp_addr(input logic [15:0] ptr);
    logic [15:0] s;
    s = 16'hE000 + ptr;
    s[0] = 1'b0;
    return s;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Write monitor: every accepted write must match the oldest expectation.
  initial forever begin
    logic [31:0] exp;
    @(negedge clk);
    if (mem_bus.mem_req === 1'b1 && mem_bus.mem_gnt === 1'b1) begin
      grant_cnt++;
      last_grant_cyc = cyc;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                 mem_bus.mem_addr, mem_bus.mem_wdata);
      end else begin
        exp = exp_q.pop_front();
        if ({mem_bus.mem_addr, mem_bus.mem_wdata} !== exp) begin
          n_fail++;
          $display("FAIL write_record: got %h_%h, required %h_%h",
                   mem_bus.mem_addr, mem_bus.mem_wdata, exp[31:16], exp[15:0]);
        end
      end
    end
    if (mem_bus.mem_req === 1'b0) begin
      n_checks++;
      if (mem_bus.mem_addr !== 16'h0000 || mem_bus.mem_wdata !== 16'h0000) begin
        n_fail++;
        $display("FAIL idle_bus_zero: got addr=%h data=%h, required 0000/0000",
                 mem_bus.mem_addr, mem_bus.mem_wdata);
      end
    end
    if (flush_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_entry(input logic [15:0] ptr, input logic [15:0] pc,
                             input bit expect_write);
    hw_wr_en      = 1'b1;
    cflow_log_ptr = ptr;
    pc_nxt        = pc;
    if (expect_write) exp_q.push_back({exp_addr(ptr), pc});
  endtask

  task automatic drain(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (busy === 1'b0 && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if (mem_bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b, required 0", mem_bus.mem_req); end
    n_checks++;
    if (mem_bus.mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr: got %h, required 0000", mem_bus.mem_addr); end
    n_checks++;
    if (mem_bus.mem_wdata !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_wdata: got %h, required 0000", mem_bus.mem_wdata); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, required 0", ovf); end
    n_checks++;
    if (flush_done !== 1'b0) begin n_fail++; $display("FAIL reset_flush_done: got %b, required 0", flush_done); end
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_single();
    mem_bus.mem_gnt = 1'b1;
    drive_entry(16'h0004, 16'hE1F0, 1'b1);
    tick();
    hw_wr_en = 1'b0;
    n_checks++;
    if (mem_bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL single_req_early: got %b, required 0", mem_bus.mem_req); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_queued: got %b, required 1", busy); end
    tick();
    n_checks++;
    if (mem_bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL single_req_latency: got %b, required 1", mem_bus.mem_req); end
    n_checks++;
    if (mem_bus.mem_addr !== 16'hE004) begin n_fail++; $display("FAIL single_addr: got %h, required E004", mem_bus.mem_addr); end
    n_checks++;
    if (mem_bus.mem_wdata !== 16'hE1F0) begin n_fail++; $display("FAIL single_data: got %h, required E1F0", mem_bus.mem_wdata); end
    tick();
    n_checks++;
    if (busy !== 1'b0 || mem_bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: got busy=%b req=%b, required 0/0", busy, mem_bus.mem_req);
    end
  endtask

  task automatic test_stall();
    int g0;
    mem_bus.mem_gnt = 1'b0;
    drive_entry(16'h0010, 16'h1234, 1'b1);
    tick();
    hw_wr_en = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 16'hE010 || mem_bus.mem_wdata !== 16'h1234) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got req=%b addr=%h data=%h, required 1/E010/1234",
                 i, mem_bus.mem_req, mem_bus.mem_addr, mem_bus.mem_wdata);
      end
      if (i < 4) tick();
    end
    g0 = grant_cnt;
    mem_bus.mem_gnt = 1'b1;
    tick();
    n_checks++;
    if (grant_cnt - g0 !== 1 || mem_bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_retire: got grants=%0d req=%b, required 1/0", grant_cnt - g0, mem_bus.mem_req);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ptrs [4];
    int g0;
    ptrs[0] = 16'h0041; ptrs[1] = 16'h2002; ptrs[2] = 16'h1FFE; ptrs[3] = 16'h0044;
    mem_bus.mem_gnt = 1'b1;
    g0 = grant_cnt;
    for (int i = 0; i < 4; i++) begin
      drive_entry(ptrs[i], 16'h5000 + 16'(i), 1'b1);
      tick();
      if (i > 0) begin
        n_checks++;
        if (mem_bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL b2b_req[%0d]: got %b, required 1", i, mem_bus.mem_req); end
      end
    end
    hw_wr_en = 1'b0;
    tick();
    n_checks++;
    if (mem_bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL b2b_req_tail: got %b, required 1", mem_bus.mem_req); end
    tick();
    n_checks++;
    if (mem_bus.mem_req !== 1'b0 || grant_cnt - g0 !== 4) begin
      n_fail++;
      $display("FAIL b2b_retire: got req=%b grants=%0d, required 0/4", mem_bus.mem_req, grant_cnt - g0);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    mem_bus.mem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_entry(16'(2 * i), 16'hA000 + 16'(i), i < 4);
      tick();
      if (i == 3) begin
        n_checks++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b, required 0", ovf); end
      end
      if (i == 4) begin
        n_checks++;
        if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b, required 1", ovf); end
      end
    end
    hw_wr_en = 1'b0;
    mem_bus.mem_gnt = 1'b1;
    drain(20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ovf_drain: got pending=%0d busy=%b, required 0/0", exp_q.size(), busy); end
    tick();
    n_checks++;
    if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b, required 1", ovf); end
  endtask

  task automatic test_full_pop();
    bit ok;
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_reset_clear: got %b, required 0", ovf); end
    mem_bus.mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_entry(16'h0020 + 16'(2 * i), 16'hB000 + 16'(i), 1'b1);
      tick();
    end
    drive_entry(16'h0028, 16'hB004, 1'b1);
    mem_bus.mem_gnt = 1'b1;
    tick();
    hw_wr_en = 1'b0;
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf: got %b, required 0", ovf); end
    drain(20, ok);
    n_checks++;
    if (!ok || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL fullpop_drain: got pending=%0d ovf=%b, required 0/0", exp_q.size(), ovf);
    end
  endtask

  task automatic test_flush();
    bit ok;
    int g0, f0;
    mem_bus.mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_entry(16'h0100 + 16'(2 * i), 16'hC000 + 16'(i), 1'b1);
      tick();
    end
    hw_wr_en = 1'b0;
    g0 = grant_cnt;
    f0 = fd_cnt;
    flush = 1'b1;
    tick();
    drive_entry(16'h0106, 16'hC003, 1'b1);
    tick();
    hw_wr_en = 1'b0;
    n_checks++;
    if (flush_done !== 1'b0) begin n_fail++; $display("FAIL flush_early: got %b, required 0", flush_done); end
    mem_bus.mem_gnt = 1'b1;
    drain(20, ok);
    tick();
    tick();
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL flush_drain: got pending=%0d, required 0", exp_q.size()); end
    n_checks++;
    if (grant_cnt - g0 !== 4) begin n_fail++; $display("FAIL flush_grants: got %0d, required 4", grant_cnt - g0); end
    n_checks++;
    if (fd_cnt - f0 !== 1) begin n_fail++; $display("FAIL flush_done_count: got %0d, required 1", fd_cnt - f0); end
    n_checks++;
    if (fd_cyc !== last_grant_cyc + 1) begin
      n_fail++;
      $display("FAIL flush_done_timing: got cycle %0d, required %0d", fd_cyc, last_grant_cyc + 1);
    end
    flush = 1'b0;
    tick();
  endtask

  task automatic test_flush_idle();
    int f0;
    f0 = fd_cnt;
    flush = 1'b1;
    tick();
    n_checks++;
    if (flush_done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_pulse: got done=%b busy=%b, required 1/0", flush_done, busy);
    end
    tick();
    n_checks++;
    if (flush_done !== 1'b0) begin n_fail++; $display("FAIL flush_idle_one_cycle: got %b, required 0", flush_done); end
    flush = 1'b0;
    tick();
    n_checks++;
    if (fd_cnt - f0 !== 1) begin n_fail++; $display("FAIL flush_idle_count: got %0d, required 1", fd_cnt - f0); end
  endtask

  task automatic test_reset_issue();
    int g0;
    mem_bus.mem_gnt = 1'b0;
    drive_entry(16'h0200, 16'hD000, 1'b1);
    tick();
    drive_entry(16'h0202, 16'hD001, 1'b1);
    tick();
    hw_wr_en = 1'b0;
    n_checks++;
    if (mem_bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_issue_setup: got %b, required 1", mem_bus.mem_req); end
    g0 = grant_cnt;
    reset_n = 1'b0;
    mem_bus.mem_gnt = 1'b1;
    #1;
    n_checks++;
    if (mem_bus.mem_req !== 1'b0 || busy !== 1'b0 || mem_bus.mem_addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_issue_immediate: got req=%b busy=%b addr=%h, required 0/0/0000",
               mem_bus.mem_req, busy, mem_bus.mem_addr);
    end
    exp_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    n_checks++;
    if (mem_bus.mem_req !== 1'b0 || busy !== 1'b0 || grant_cnt !== g0) begin
      n_fail++;
      $display("FAIL rst_issue_discard: got req=%b busy=%b grants=%0d, required 0/0/0",
               mem_bus.mem_req, busy, grant_cnt - g0);
    end
  endtask

  initial begin
    mem_bus.mem_gnt = 1'b0;
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_overflow();
    do_reset();
    test_full_pop();
    test_flush();
    test_flush_idle();
    test_reset_issue();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d, required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cflog_writer.md
CFLOG_WRITER -- requirements
Module: cflog_writer

Interface
REQ-001 Parameter LOG_BASE, default 16'hE000, byte base address of the CFLog region in data memory.
REQ-002 Parameter FIFO_DEPTH, default 4, number of buffered log entries; power of two, minimum 2.
REQ-003 Port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port hw_wr_en  input  1  log-write request from the log monitor, one entry per cycle high.
REQ-006 Port cflow_log_ptr  input  16  byte offset of the entry within the log, even.
REQ-007 Port pc_nxt  input  16  branch destination to record.
REQ-008 Port flush  input  1  log monitor flush request, level.
REQ-009 Port mem_req  output  1  memory write request.
REQ-010 Port mem_addr  output  16  byte write address.
REQ-011 Port mem_wdata  output  16  write data.
REQ-012 Port mem_gnt  input  1  memory accepts the write in the cycle where mem_req and mem_gnt are both high.
REQ-013 Port busy  output  1  FIFO non-empty or write outstanding.
REQ-014 Port ovf  output  1  sticky overflow flag; an entry was dropped.
REQ-015 Port flush_done  output  1  one-cycle pulse; all entries accepted before flush rose are in memory.

Function
REQ-016 Entry = {LOG_BASE + cflow_log_ptr, pc_nxt}, captured when hw_wr_en=1; add is 16-bit modulo 2^16, carry dropped.
REQ-017 Captured entries enter the FIFO at the next rising edge (1-cycle capture latency).
REQ-018 FSM states: IDLE, ISSUE, FLUSH.
REQ-019 IDLE->ISSUE when the FIFO is non-empty; IDLE->FLUSH when a flush rising edge is seen with the FIFO empty.
REQ-020 ISSUE: mem_req=1, mem_addr/mem_wdata = FIFO head, held stable until grant; on grant, pop the head.
REQ-021 ISSUE->IDLE on grant when the FIFO becomes empty and no flush is pending; ISSUE->FLUSH on grant when it becomes empty and flush is pending.
REQ-022 FLUSH lasts exactly one cycle: flush_done=1, then ->IDLE, or ->ISSUE if the FIFO is non-empty.
REQ-023 Flush pending is set on a flush 0->1 edge, including during ISSUE, and cleared in FLUSH.
REQ-024 Entries captured while flush is pending are written before flush_done.
REQ-025 Minimum hw_wr_en-to-mem_req latency: 2 cycles from an empty FIFO (capture edge, then state edge).
REQ-026 Back-to-back writes: with mem_gnt held at 1, one entry retires per cycle, and mem_req stays high while the FIFO is non-empty.
REQ-027 When the FIFO is full and hw_wr_en=1 with no pop in the same cycle, drop the entry and set ovf=1.
REQ-028 When the FIFO is full and hw_wr_en=1 with a pop in the same cycle, accept the entry and leave ovf unchanged.
REQ-029 ovf clears only on reset.
REQ-030 mem_addr and mem_wdata read 0 when mem_req=0.
REQ-031 busy = (FIFO count != 0) | mem_req.
REQ-032 If an odd cflow_log_ptr is captured, force bit 0 of the address to 0.

Reset
REQ-033 On reset_n=0, immediately: state=IDLE, FIFO empty, pointers=0, flush pending=0, mem_req=0, mem_addr=0, mem_wdata=0, busy=0, ovf=0, flush_done=0.
REQ-034 Reset mid-ISSUE discards the outstanding write and all buffered entries; no write completes after reset asserts.
REQ-035 The first capture after reset_n deasserts occurs at the first rising edge with reset_n=1.

Structure
REQ-036 A shared package cflog_pkg holds the FSM state encoding (IDLE=2'b00, ISSUE=2'b01, FLUSH=2'b10), the entry record type {addr[15:0], data[15:0]} and the LOG_BASE default.
REQ-037 The FIFO is a sub-module cflog_fifo with push, pop, full, empty, count, head and asynchronous active-low reset.

Verification
REQ-038 Single write: reset, ptr=16'h0004, pc_nxt=16'hE1F0, hw_wr_en pulse, mem_gnt=1 -> mem_req 2 cycles later with addr=16'hE004, data=16'hE1F0; busy drops the next cycle.
REQ-039 Stall: mem_gnt=0 for 5 cycles -> mem_req, addr and data held constant for 5 cycles; entry retires on the first grant.
REQ-040 Overflow: mem_gnt=0, 5 consecutive hw_wr_en (ptr 0,2,4,6,8) -> ovf=1 after the 5th; after grants only ptr 0..6 appear in memory.
REQ-041 Full with simultaneous pop: FIFO full, mem_gnt=1 and hw_wr_en=1 in the same cycle -> entry accepted, ovf stays 0.
REQ-042 Flush: 3 entries queued, flush rises, 1 more entry captured -> flush_done pulses exactly once, one cycle after the 4th grant.
REQ-043 Reset during ISSUE with 2 entries queued -> mem_req=0 immediately, no further grants consumed, busy=0.
